serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor with a start/busy/done handshake. It is the next generation of the 4-bit serial adder block and adds four things: generic operand width, a subtract mode, a signed overflow flag, and result registers that hold their value between operations. The block loads two WIDTH-bit operands in parallel and processes one bit per clock, LSB first, through a single full adder and a carry flip-flop. It sits in FPGA datapath experiments as a small, low-area arithmetic unit driven by a controller or test harness.

---
 rtl/serial_addsub.sv | 78 +++++++
 tb/tb_serial_addsub.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor, one bit per clock LSB first, start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sha_q, shb_q, sum_q;
  logic [WIDTH-2:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q, cout_q, ovf_q, busy_q, done_q;
  logic             bit_d, c_d, last;
  logic [WIDTH-1:0] acc_d;
  assign bit_d = sha_q[0] ^ shb_q[0] ^ c_q;
  assign c_d   = (sha_q[0] & shb_q[0]) | (sha_q[0] & c_q) | (shb_q[0] & c_q);
  assign acc_d = {bit_d, acc_q};
  assign last  = cnt_q == CNT_W'(WIDTH - 1);
  // Subtraction feeds ~B with the carry preset to 1, so one full adder serves both modes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          sha_q   <= A;
          shb_q   <= sub ? ~B : B;
          c_q     <= sub;
          cnt_q   <= '0;
          acc_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
      end else begin
        sha_q <= sha_q >> 1;
        shb_q <= shb_q >> 1;
        c_q   <= c_d;
        acc_q <= acc_d[WIDTH-1:1];
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          sum_q   <= acc_d;
          cout_q  <= c_d;
          ovf_q   <= c_q ^ c_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed checks of 8-bit and 4-bit serial_addsub instances.
module tb_serial_addsub;
  logic       clk = 1'b0, reset = 1'b1;
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, cout8, ovf8;
  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy4, done4, cout4, ovf4;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );
  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  // Called at #1 after a clock edge; lat is the edge count after acceptance at which done appears (0 = never).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output int lat, output logic held, output logic overlap);
    logic [7:0] s0;
    logic c0, o0;
    s0 = sum8; c0 = cout8; o0 = ovf8;
    held = 1'b1; overlap = 1'b0; lat = 0;
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; sub8 = ~s;
    if (!busy8) held = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (busy8 && done8) overlap = 1'b1;
      if (done8) lat = k;
      else if (sum8 !== s0 || cout8 !== c0 || ovf8 !== o0) held = 1'b0;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, output int lat);
    lat = 0;
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~a; b4 = ~b;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done4) lat = k;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      errors++; $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy8, done8, sum8, cout8, ovf8);
    end
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 8'h0) begin
      errors++; $display("FAIL reset4 got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy4, done4, sum4, cout4, ovf4);
    end
  endtask

  task automatic test_add;
    int lat; logic held, ov;
    op8(8'h5A, 8'h3C, 1'b0, lat, held, ov);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL add_latency got %0d want 8", lat); end
    checks++;
    if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_5A_3C got sum=%h cout=%b ovf=%b want 96 0 1", sum8, cout8, ovf8);
    end
    checks++;
    if (!held || ov) begin errors++; $display("FAIL add_hold got held=%b overlap=%b want 1 0", held, ov); end
  endtask

  task automatic test_sub;
    int lat; logic held, ov;
    op8(8'h10, 8'h20, 1'b1, lat, held, ov);
    checks++;
    if ({sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0} || lat !== 8) begin
      errors++; $display("FAIL sub_10_20 got sum=%h cout=%b ovf=%b lat=%0d want F0 0 0 8", sum8, cout8, ovf8, lat);
    end
    op8(8'h20, 8'h10, 1'b1, lat, held, ov);
    checks++;
    if ({sum8, cout8, ovf8} !== {8'h10, 1'b1, 1'b0} || lat !== 8) begin
      errors++; $display("FAIL sub_20_10 got sum=%h cout=%b ovf=%b lat=%0d want 10 1 0 8", sum8, cout8, ovf8, lat);
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0, first = 0;
    logic held = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
      if (k == 4) start8 = 1'b0;
      if (done8) begin ndone++; if (first == 0) first = k; end
      else if (first == 0 && sum8 !== 8'h10) held = 1'b0;
    end
    checks++;
    if (ndone !== 1 || first !== 8) begin
      errors++; $display("FAIL ignore_start got dones=%0d at=%0d want 1 at 8", ndone, first);
    end
    checks++;
    if ({sum8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_FF_01 got sum=%h cout=%b ovf=%b want 00 1 0", sum8, cout8, ovf8);
    end
    checks++;
    if (!held) begin errors++; $display("FAIL ignore_hold got changed want sum held at 10"); end
  endtask

  task automatic test_back_to_back;
    int lat; logic held, ov;
    op8(8'h5A, 8'h3C, 1'b0, lat, held, ov);
    checks++;
    if (!done8) begin errors++; $display("FAIL b2b_first got done=%b want 1", done8); end
    op8(8'h03, 8'h04, 1'b0, lat, held, ov);
    checks++;
    if (lat !== 8 || sum8 !== 8'h07 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++; $display("FAIL b2b_second got lat=%0d sum=%h cout=%b ovf=%b want 8 07 0 0", lat, sum8, cout8, ovf8);
    end
    checks++;
    if (!held || ov) begin errors++; $display("FAIL b2b_hold got held=%b overlap=%b want 1 0", held, ov); end
  endtask

  task automatic test_reset_mid_op;
    int lat, ndone = 0; logic held, ov;
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy8, done8, sum8, cout8, ovf8);
    end
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    checks++;
    if (ndone !== 0 || sum8 !== 8'h00) begin
      errors++; $display("FAIL reset_abort got activity=%0d sum=%h want 0 00", ndone, sum8);
    end
    op8(8'h5A, 8'h3C, 1'b0, lat, held, ov);
    checks++;
    if (lat !== 8 || {sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_recover got lat=%0d sum=%h cout=%b ovf=%b want 8 96 0 1", lat, sum8, cout8, ovf8);
    end
  endtask

  task automatic test_width4;
    int lat;
    op4(4'h7, 4'h1, 1'b0, lat);
    checks++;
    if (lat !== 4 || {sum4, cout4, ovf4} !== {4'h8, 1'b0, 1'b1}) begin
      errors++; $display("FAIL w4_add_7_1 got lat=%0d sum=%h cout=%b ovf=%b want 4 8 0 1", lat, sum4, cout4, ovf4);
    end
    op4(4'h0, 4'h1, 1'b1, lat);
    checks++;
    if (lat !== 4 || {sum4, cout4, ovf4} !== {4'hF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL w4_sub_0_1 got lat=%0d sum=%h cout=%b ovf=%b want 4 F 0 0", lat, sum4, cout4, ovf4);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    test_add;
    test_sub;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_op;
    test_width4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
